// File: rtl/regfile_alu_sequencer.sv
// Four-phase instruction sequencer for the 8x8 register file:
// IDLE (accept) -> READ (sample operands) -> EXEC (compute) -> WRITE (commit).
// Owns the register file write port and keeps the last written addr/data pair
// on it, so the file's addr-match bypass always returns the stored value.
module regfile_alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs0,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] rf_read_addr0,
    output logic [ADDR_W-1:0] rf_read_addr1,
    input  logic [DATA_W-1:0] rf_read_data0,
    input  logic [DATA_W-1:0] rf_read_data1,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic              carry,
    output logic              busy
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd5;
    localparam logic [2:0] OP_ADDI = 3'd6;
    localparam logic [2:0] OP_CMP  = 3'd7;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    // Latched instruction fields (sources go straight into the read-address regs)
    typedef struct packed {
        logic [2:0]        op;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] imm;
    } instr_t;

    state_t            state, state_nxt;
    instr_t            instr_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W:0]   alu_res;   // {carry/borrow, result}
    logic              accept;
    logic              writes;

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = instr_valid && instr_ready;
    assign writes      = (instr_q.op != OP_CMP);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: one step per edge once an instruction is taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the instruction and present its source addresses for the READ cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q       <= '0;
            rf_read_addr0 <= '0;
            rf_read_addr1 <= '0;
        end else if (accept) begin
            instr_q       <= '{op: instr_op, rd: instr_rd, imm: instr_imm};
            rf_read_addr0 <= instr_rs0;
            rf_read_addr1 <= instr_rs1;
        end
    end

    // Capture the combinational read data at the end of READ
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (state == READ) begin
            a_q <= rf_read_data0;
            b_q <= rf_read_data1;
        end
    end

    // ALU; the 9-bit subtract leaves the borrow in the top bit
    always_comb begin
        alu_res = '0;
        case (instr_q.op)
            OP_ADD:  alu_res = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  alu_res = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  alu_res = {1'b0, a_q & b_q};
            OP_OR:   alu_res = {1'b0, a_q | b_q};
            OP_XOR:  alu_res = {1'b0, a_q ^ b_q};
            OP_LDI:  alu_res = {1'b0, instr_q.imm};
            OP_ADDI: alu_res = {1'b0, a_q} + {1'b0, instr_q.imm};
            OP_CMP:  alu_res = {1'b0, a_q} - {1'b0, b_q};
            default: alu_res = '0;
        endcase
    end

    // Result and write port; the addr/data pair only moves for writing ops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid    <= 1'b0;
            rf_write_enable <= 1'b0;
            result_data     <= '0;
            carry           <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else begin
            result_valid    <= (state == EXEC);
            rf_write_enable <= (state == EXEC) && writes;
            if (state == EXEC) begin
                result_data <= alu_res[DATA_W-1:0];
                carry       <= alu_res[DATA_W];
                if (writes) begin
                    rf_write_addr <= instr_q.rd;
                    rf_write_data <= alu_res[DATA_W-1:0];
                end
            end
        end
    end

endmodule

// File: doc/regfile_alu_sequencer.md
Name: regfile_alu_sequencer

Overview:
Initiator-side controller for the 8x8 register file: accepts one instruction at a time over a valid/ready handshake and reads two source registers through the file's combinational read ports. It computes an 8-bit ALU result and drives the file's write port to write it back.
Sits between the lab instruction source (switches or testbench) and the register file. It is the only block driving the file's write port.

Parameters:
DATA_W, 8, register and ALU width (fixed; matches the register file)
ADDR_W, 3, register address width (8 registers)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
instr_valid  in  1  instruction present
instr_ready  out  1  block can accept an instruction (high only in IDLE)
instr_op  in  3  opcode
instr_rd  in  3  destination register
instr_rs0  in  3  source register 0
instr_rs1  in  3  source register 1
instr_imm  in  8  immediate
rf_read_addr0  out  3  to register file read_addr0
rf_read_addr1  out  3  to register file read_addr1
rf_read_data0  in  8  from register file read_data0 (combinational)
rf_read_data1  in  8  from register file read_data1 (combinational)
rf_write_addr  out  3  to register file write_addr
rf_write_data  out  8  to register file write_data
rf_write_enable  out  1  to register file write_enable
result_valid  out  1  one-cycle pulse, result_data/carry valid
result_data  out  8  ALU result
carry  out  1  carry-out / borrow flag
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high. Every register clears on the reset edge regardless of clk.
- Reset values:
  - state=IDLE, so instr_ready=1 and busy=0.
  - rf_write_enable=0, result_valid=0.
  - result_data, carry, rf_write_addr, rf_write_data, rf_read_addr0/1 and all latched fields are 0.
- FSM states are IDLE, READ, EXEC and WRITE, advancing one state per clk edge.
- IDLE:
  - Accept when instr_valid && instr_ready at an edge (E0).
  - Latch op, rd, rs0, rs1 and imm, then go to READ.
  - instr_valid with instr_ready low is ignored. The source must hold the instruction until accepted.
- READ:
  - rf_read_addr0/1 are registered and loaded with rs0/rs1 at E0, so they are stable for the whole READ cycle.
  - At E1, capture rf_read_data0/1 into operand registers a and b, then go to EXEC.
- EXEC: at E2, register result_data and carry, then go to WRITE. For writing ops, also load rf_write_addr=rd and rf_write_data=result.
- WRITE:
  - For writing ops, rf_write_enable=1 for exactly this cycle; the register file stores at E3.
  - result_valid=1 for this cycle.
  - At E3, go to IDLE.
- Latency and throughput: accept at E0, write committed at E3, one instruction per 4 cycles.
- Write-port hold rule:
  - rf_write_addr and rf_write_data change only at E2 of a writing op and otherwise hold the last written pair.
  - This matters because the register file bypasses write_data whenever read_addr equals write_addr, independent of write_enable.
  - Holding the last written pair guarantees any bypassed read returns the value actually stored, including rd==rs0 back-to-back cases.
- Opcodes (all arithmetic mod 256):
  - 000 ADD: a+b, carry=bit 8 of the 9-bit sum.
  - 001 SUB: a-b, carry=1 if a<b (borrow).
  - 010 AND, 011 OR, 100 XOR: bitwise a op b, carry=0.
  - 101 LDI: result=imm, carry=0, no reads used.
  - 110 ADDI: a+imm, carry=bit 8 of the 9-bit sum.
  - 111 CMP: result=a-b, carry=borrow. No write: rf_write_enable stays 0 and rf_write_addr/data hold, but result_valid still pulses.
- Reset mid-operation:
  - Returns to IDLE immediately; the in-flight instruction is dropped.
  - Reset asserted during WRITE must deassert rf_write_enable asynchronously, and no register is written at that edge.
- Unwritten registers: power-up register contents are undefined. Software loads with LDI before reading.

Test Plan:
1. LDI r1,0x05 accepted at cycle 0 -> rf_write_enable=1, rf_write_addr=1, rf_write_data=0x05 during cycle 3; result_valid=1 and result_data=0x05 in the same cycle; instr_ready=1 at cycle 4.
2. LDI r2,0xFF then ADD r3=r1+r2 -> write r3=0x04, carry=1. Then ADDI r4=r3+0x10 -> r4=0x14, carry=0.
3. SUB r5=r1-r2 (0x05-0xFF) -> r5=0x06, carry=1. Then XOR r6=r2^r1 -> 0xFA, carry=0.
4. LDI r1,0x05 immediately followed by ADD r1=r1+r1 -> r1=0x0A (bypass returns held 0x05). Then CMP r1,r1 -> result_valid=1, result_data=0x00, carry=0, rf_write_enable stays 0, rf_write_addr stays 1.
5. instr_valid held high with 3 queued instructions -> instr_ready high only in IDLE, accepts spaced exactly 4 cycles, busy=1 between them, no instruction dropped or duplicated.
6. ADD r7=r1+r2 in flight; assert reset during EXEC, then during WRITE on a repeat -> rf_write_enable=0 at once, r7 unchanged (read back via CMP), all outputs at reset values, and the next instruction is accepted one cycle after reset release.
